prbs_pattern_gen: RTL and testbench

- Parametrised successor to the team's PRBS-15 byte generator.
- Loads an N-byte pattern and emits it one byte per handshake, LSB byte first, for a programmable number of repetitions.
- Then emits the same byte stream scrambled with a selectable PRBS (7/15/23/31) keystream.
- Sits between a link-training controller and a byte-wide serializer; adds start/stop control and a valid/ready handshake.

---
 rtl/prbs_pattern_gen_pkg.sv | 59 +++++
 rtl/prbs_pattern_gen_if.sv | 12 +
 rtl/prbs_pattern_gen_lfsr_step8.sv | 29 ++
 rtl/prbs_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_prbs_pattern_gen.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pattern_gen_pkg.sv
// rtl/prbs_pattern_gen_pkg.sv - shared types and LFSR tables for the PRBS pattern generator
// Purpose: mode and state encodings, LFSR width, per-mode taps/width masks and
//          the per-mode seed derivation used by the generator and its LFSR stepper.
// Ports: none (package).
package prbs_pkg;

  localparam int LFSR_W = 31;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS23 = 2'd2,
    MODE_PRBS31 = 2'd3
  } prbs_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PATTERN  = 2'd1,
    ST_SCRAMBLE = 2'd2
  } prbs_state_e;

  // First tap is always the top bit of the active register width.
  function automatic logic [4:0] tap_a(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return 5'd6;
      MODE_PRBS15: return 5'd14;
      MODE_PRBS23: return 5'd22;
      default:     return 5'd30;
    endcase
  endfunction

  function automatic logic [4:0] tap_b(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return 5'd5;
      MODE_PRBS15: return 5'd13;
      MODE_PRBS23: return 5'd17;
      default:     return 5'd27;
    endcase
  endfunction

  // Keeps register bits above the active width at zero.
  function automatic logic [LFSR_W-1:0] width_mask(input prbs_mode_e m);
    case (m)
      MODE_PRBS7:  return 31'h0000_007F;
      MODE_PRBS15: return 31'h0000_7FFF;
      MODE_PRBS23: return 31'h007F_FFFF;
      default:     return 31'h7FFF_FFFF;
    endcase
  endfunction

  // An all-zero LFSR would lock up, so a seed that masks to zero becomes all-ones.
  function automatic logic [LFSR_W-1:0] seed_for_mode(input logic [LFSR_W-1:0] seed,
                                                      input prbs_mode_e m);
    logic [LFSR_W-1:0] s;
    s = seed & width_mask(m);
    return (s == '0) ? width_mask(m) : s;
  endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// rtl/prbs_pattern_gen_if.sv - byte output handshake bundle of the PRBS pattern generator
// Purpose: groups the byte stream valid/ready handshake.
// Ports: out_valid, byte_out, scrambled (generator -> sink); out_ready (sink -> generator).
interface prbs_pattern_gen_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] byte_out;
  logic       scrambled;

  modport master (output out_valid, output byte_out, output scrambled, input out_ready);
  modport slave  (input out_valid, input byte_out, input scrambled, output out_ready);
endinterface

// File: rtl/prbs_pattern_gen_lfsr_step8.sv
// rtl/prbs_pattern_gen_lfsr_step8.sv - eight unrolled Fibonacci LFSR steps for one keystream byte
// Purpose: combinational; advances the LFSR eight steps for the selected mode.
// Ports: mode (PRBS select), state_in (current LFSR), state_out (LFSR after
//        eight steps), ks (keystream byte, first output bit in bit0).
module prbs_lfsr_step8
  import prbs_pkg::*;
(
  input  prbs_mode_e        mode,
  input  logic [LFSR_W-1:0] state_in,
  output logic [LFSR_W-1:0] state_out,
  output logic [7:0]        ks
);

  logic [LFSR_W-1:0] s;
  logic              nb;

  always_comb begin
    s  = state_in;
    nb = 1'b0;
    ks = '0;
    for (int i = 0; i < 8; i++) begin
      nb    = s[tap_a(mode)] ^ s[tap_b(mode)];
      s     = {s[LFSR_W-2:0], nb} & width_mask(mode);
      ks[i] = nb;
    end
    state_out = s;
  end

endmodule

// File: rtl/prbs_pattern_gen.sv
// rtl/prbs_pattern_gen.sv - pattern repeater followed by PRBS-scrambled byte stream
// Purpose: emits a captured NUM_BYTES pattern LSB byte first repeat_n times, then
//          the same bytes XORed with a PRBS7/15/23/31 keystream until stop.
// Ports: clk, rst (async, active high), enable (global freeze when low), start,
//        stop, pattern_in, repeat_n, mode, busy; out_if carries out_valid,
//        out_ready, byte_out and scrambled.
// Optional: define PRBS_ERR_INJECT_EN to add err_inject, which inverts bit0 of
//           the scrambled byte loaded on that cycle.
module prbs_pattern_gen
  import prbs_pkg::*;
#(
  parameter int                NUM_BYTES = 4,
  parameter int                REP_W     = 8,
  parameter logic [LFSR_W-1:0] SEED      = 31'h7FFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic [8*NUM_BYTES-1:0] pattern_in,
  input  logic [REP_W-1:0]       repeat_n,
  input  logic [1:0]             mode,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                   err_inject,
`endif
  output logic                   busy,
  prbs_pattern_gen_if.master     out_if
);

  localparam int                IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BYTES - 1);

  prbs_state_e            state;
  logic [8*NUM_BYTES-1:0] cap_pattern;
  logic [REP_W-1:0]       cap_rep;
  logic [REP_W-1:0]       rep_cnt;
  prbs_mode_e             cap_mode;
  logic [IDX_W-1:0]       idx;
  logic [LFSR_W-1:0]      lfsr;
  logic                   out_valid_q;
  logic [7:0]             byte_q;
  logic                   scrambled_q;

  logic [7:0]        pat_bytes [NUM_BYTES];
  logic [IDX_W-1:0]  next_idx;
  prbs_mode_e        step_mode;
  logic [LFSR_W-1:0] step_in;
  logic [LFSR_W-1:0] step_out;
  logic [7:0]        ks;
  logic [7:0]        inj;
  logic              xfer;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_bytes
    assign pat_bytes[g] = cap_pattern[8*g +: 8];
  end

`ifdef PRBS_ERR_INJECT_EN
  assign inj = {7'd0, err_inject};
`else
  assign inj = 8'd0;
`endif

  assign next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign xfer     = out_valid_q && out_if.out_ready;

  // lfsr always holds the state for the byte after the one on byte_out, so a
  // single stepper serves both start (fed from the seed) and later transfers.
  assign step_mode = (state == ST_IDLE) ? prbs_mode_e'(mode) : cap_mode;
  assign step_in   = (state == ST_IDLE) ? seed_for_mode(SEED, prbs_mode_e'(mode)) : lfsr;

  prbs_lfsr_step8 u_step (
    .mode      (step_mode),
    .state_in  (step_in),
    .state_out (step_out),
    .ks        (ks)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cap_pattern <= '0;
      cap_rep     <= '0;
      rep_cnt     <= '0;
      cap_mode    <= MODE_PRBS7;
      idx         <= '0;
      lfsr        <= SEED;
      out_valid_q <= 1'b0;
      byte_q      <= '0;
      scrambled_q <= 1'b0;
      busy        <= 1'b0;
    end else if (enable) begin
      if (stop) begin
        state       <= ST_IDLE;
        out_valid_q <= 1'b0;
        scrambled_q <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cap_pattern <= pattern_in;
              cap_rep     <= repeat_n;
              cap_mode    <= prbs_mode_e'(mode);
              idx         <= '0;
              rep_cnt     <= '0;
              out_valid_q <= 1'b1;
              busy        <= 1'b1;
              if (repeat_n != '0) begin
                state       <= ST_PATTERN;
                lfsr        <= step_in;
                byte_q      <= pattern_in[7:0];
                scrambled_q <= 1'b0;
              end else begin
                state       <= ST_SCRAMBLE;
                lfsr        <= step_out;
                byte_q      <= pattern_in[7:0] ^ ks ^ inj;
                scrambled_q <= 1'b1;
              end
            end
          end
          ST_PATTERN: begin
            if (xfer) begin
              idx <= next_idx;
              if (idx == LAST_IDX) begin
                if ((rep_cnt + REP_W'(1)) == cap_rep) begin
                  state       <= ST_SCRAMBLE;
                  lfsr        <= step_out;
                  byte_q      <= pat_bytes[0] ^ ks ^ inj;
                  scrambled_q <= 1'b1;
                end else begin
                  rep_cnt <= rep_cnt + REP_W'(1);
                  byte_q  <= pat_bytes[0];
                end
              end else begin
                byte_q <= pat_bytes[next_idx];
              end
            end
          end
          ST_SCRAMBLE: begin
            if (xfer) begin
              idx    <= next_idx;
              lfsr   <= step_out;
              byte_q <= pat_bytes[next_idx] ^ ks ^ inj;
            end
          end
          default: begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            scrambled_q <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.byte_out  = byte_q;
  assign out_if.scrambled = scrambled_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// tb/tb_prbs_pattern_gen.sv - scoreboard bench for prbs_pattern_gen
module tb_prbs_pattern_gen;
  import prbs_pkg::*;

  localparam int          NB     = 4;
  localparam logic [30:0] SEED_V = 31'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] pattern_in = '0;
  logic [7:0]  repeat_n = '0;
  logic [1:0]  mode = '0;
`ifdef PRBS_ERR_INJECT_EN
  logic        err_inject = 1'b0;
`endif
  logic        busy;

  prbs_pattern_gen_if ifc ();

  prbs_pattern_gen #(.NUM_BYTES(NB), .REP_W(8), .SEED(SEED_V)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .pattern_in (pattern_in),
    .repeat_n   (repeat_n),
    .mode       (mode),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject (err_inject),
`endif
    .busy       (busy),
    .out_if     (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  logic [8:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: the keystream obeys b[n] = b[n-1-a] ^ b[n-1-b], with the seed
  // providing the W bits before the first output (seed bit0 most recent).
  task automatic push_expected(input logic [31:0] pat, input int rep, input int m,
                               input int n_scr, input int first_exp, input bit flip_first);
    int   w, a, b, n;
    logic [31:0] msk, s;
    bit   bits [$];
    logic [7:0] kb, by;
    case (m)
      0: begin w = 7;  b = 5;  end
      1: begin w = 15; b = 13; end
      2: begin w = 23; b = 17; end
      default: begin w = 31; b = 27; end
    endcase
    a   = w - 1;
    msk = (32'h1 << w) - 32'h1;
    s   = {1'b0, SEED_V} & msk;
    if (s == 0) s = msk;
    for (int j = 0; j < w; j++) bits.push_back(s[w-1-j]);
    for (int r = 0; r < rep; r++)
      for (int i = 0; i < NB; i++) sb.push_back({1'b0, pat[8*i +: 8]});
    for (int j = 0; j < n_scr; j++) begin
      kb = '0;
      for (int k = 0; k < 8; k++) begin
        n = bits.size();
        bits.push_back(bits[n-1-a] ^ bits[n-1-b]);
        kb[k] = bits[n];
      end
      by = pat[8*(j % NB) +: 8] ^ kb;
      if (j == 0 && flip_first) by[0] = ~by[0];
      if (j == 0 && first_exp >= 0) by = first_exp[7:0];
      sb.push_back({1'b1, by});
    end
  endtask

  function automatic logic rdy(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (cyc % 2) == 0;
    return $urandom_range(0, 1) == 1;
  endfunction

  // Monitor: pops and compares on every transfer, checks hold while stalled.
  logic       have_hold = 1'b0;
  logic [7:0] hold_b;
  logic       hold_s;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_hold = 1'b0;
      end else begin
        if (have_hold) begin
          chk("hold_valid", ifc.out_valid, 1);
          chk("hold_byte", ifc.byte_out, hold_b);
          chk("hold_scr", ifc.scrambled, hold_s);
        end
        if (ifc.out_valid && ifc.out_ready && enable) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_xfer: got byte %0h expected none", ifc.byte_out);
          end else begin
            logic [8:0] e;
            e = sb.pop_front();
            chk($sformatf("byte#%0d", n_xfer), ifc.byte_out, e[7:0]);
            chk($sformatf("scr#%0d", n_xfer), ifc.scrambled, e[8]);
          end
          n_xfer++;
          have_hold = 1'b0;
        end else if (ifc.out_valid && !(stop && enable)) begin
          have_hold = 1'b1;
          hold_b    = ifc.byte_out;
          hold_s    = ifc.scrambled;
        end else begin
          have_hold = 1'b0;
        end
      end
    end
  end

  task automatic run(input logic [31:0] pat, input int rep, input int m, input int n_scr,
                     input int rmode, input int gap_at, input int first_exp, input bit inj);
    int cyc;
    push_expected(pat, rep, m, n_scr, first_exp, inj);
    pattern_in    = pat;
    repeat_n      = rep[7:0];
    mode          = m[1:0];
    start         = 1'b1;
    ifc.out_ready = rdy(rmode, 0);
`ifdef PRBS_ERR_INJECT_EN
    err_inject = inj;
`endif
    @(posedge clk) #1;
    start = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    chk("start_valid", ifc.out_valid, 1);
    chk("start_busy", busy, 1);
    cyc = 1;
    while (sb.size() != 0 && cyc < 2000) begin
      ifc.out_ready = rdy(rmode, cyc);
      if (gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 5) begin
        enable = 1'b0;
        stop   = (cyc == gap_at + 2);
      end else begin
        enable = 1'b1;
        stop   = 1'b0;
      end
      if (rmode == 2) begin
        start      = ($urandom_range(0, 3) == 0);
        pattern_in = $urandom;
        mode       = 2'($urandom_range(0, 3));
      end
      @(posedge clk) #1;
      cyc++;
    end
    chk("drain_left", sb.size(), 0);
    sb.delete();
    enable = 1'b1;
    start  = 1'b0;
    ifc.out_ready = 1'b0;
    stop   = 1'b1;
    @(posedge clk) #1;
    stop = 1'b0;
    chk("stop_valid", ifc.out_valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_scr", ifc.scrambled, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.out_ready = 1'b0;
    #12;
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_byte", ifc.byte_out, 0);
    chk("rst_scr", ifc.scrambled, 0);
    chk("rst_busy", busy, 0);
    rst    = 1'b0;
    enable = 1'b1;
    @(posedge clk) #1;

    run(32'h3ACF491E, 2, 1, 8, 0, -1, -1, 1'b0);
    run(32'h00000000, 0, 0, 6, 0, -1, 8'h40, 1'b0);
    run(32'h4DF1A98B, 1, 2, 8, 0, -1, -1, 1'b0);
    run(32'h4DF1A98B, 1, 2, 8, 1, -1, -1, 1'b0);
    run(32'h5A17C3E2, 3, 3, 4, 0, 3, -1, 1'b0);
    run(32'h600DF00D, 0, 3, 5, 0, -1, -1, 1'b0);
    run(32'h600DF00D, 1, 1, 9, 0, -1, -1, 1'b0);

    // start and stop together in IDLE: stop wins
    pattern_in = 32'h11223344; repeat_n = 8'd1; start = 1'b1; stop = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", busy, 0);
    chk("startstop_valid", ifc.out_valid, 0);
    // start ignored while enable is low
    enable = 1'b0; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    chk("frozen_start_busy", busy, 0);
    enable = 1'b1;

    // asynchronous reset mid-cycle during PATTERN
    push_expected(32'hA5C37E19, 3, 2, 0, -1, 1'b0);
    pattern_in = 32'hA5C37E19; repeat_n = 8'd3; mode = 2'd2;
    ifc.out_ready = 1'b1; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (3) @(posedge clk) #1;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", ifc.out_valid, 0);
    chk("arst_byte", ifc.byte_out, 0);
    chk("arst_scr", ifc.scrambled, 0);
    chk("arst_busy", busy, 0);
    #2 rst = 1'b0;
    sb.delete();
    ifc.out_ready = 1'b0;
    @(posedge clk) #1;
    chk("arst_idle_busy", busy, 0);

`ifdef PRBS_ERR_INJECT_EN
    run(32'h12345678, 0, 3, 4, 0, -1, -1, 1'b1);
    run(32'h12345678, 1, 0, 4, 0, -1, -1, 1'b1);
`endif

    for (int t = 0; t < 6; t++)
      run($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(4, 12),
          2, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
